entity_vector: RTL and testbench
================================

ENTITY_VECTOR -- requirements
Module: entity_vector

Interface
REQ-001 SHALL have parameters: MAX_SPEED, default 6, max velocity magnitude per axis (1..15).
REQ-002 SHALL have parameter RAMP_DELAY, default 10_000_000, clock cycles between successive velocity updates per axis (>=1).
REQ-003 SHALL have parameters STEP_NUM and FRAME_DEN, defaults 5 and 60; steps/s = |vel|*STEP_NUM*frame_rate/FRAME_DEN.
REQ-004 SHALL derive localparam VEL_W = clog2(MAX_SPEED+1)+1 (signed) and ACC_W = clog2(FRAME_DEN+MAX_SPEED*STEP_NUM).
REQ-005 Ports: clock_100mhz  in  1  sole clock; one clock; reset is asynchronous and active-low (reset_n).
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 game_active  in  1  high = motion enabled.
REQ-008 frame_tick  in  1  one-cycle pulse per display frame.
REQ-009 input_hor / input_vert  in  2 each  00 none, 01 left/up, 10 right/down, 11 none.
REQ-010 edge_left, edge_right, edge_top, edge_bot  in  1 each  entity touching that boundary.
REQ-011 vel_hor / vel_vert  out  VEL_W each  signed velocity, negative = left/up.
REQ-012 step_hor / step_vert  out  1 each  one-cycle move-one-pixel pulse.
REQ-013 dir_hor / dir_vert  out  1 each  0 = left/up, 1 = right/down; valid when step high.

Function (per axis; axes fully independent)
REQ-014 Ramp counter: when nonzero, SHALL decrement each cycle and block velocity updates.
REQ-015 With counter zero and input toward +: vel>=0 -> vel+1; vel<0 -> vel+2 (reversal braking); result clamped to +MAX_SPEED.
REQ-016 Input toward -: mirror of REQ-015, clamped to -MAX_SPEED.
REQ-017 Input none (00/11): vel moves one toward 0; vel=0 stays 0.
REQ-018 Any update that changes vel SHALL load ramp counter with RAMP_DELAY-1; unchanged vel (at clamp or 0) SHALL NOT load it.
REQ-019 Edge block: if the edge in the direction of vel's sign, or of the pressed input, is asserted, vel SHALL become 0 next cycle regardless of ramp counter, and counter SHALL clear; motion away from an asserted edge is unaffected.
REQ-020 Step accumulator: on frame_tick with vel!=0, acc <= acc + |vel|*STEP_NUM; if the sum >= FRAME_DEN, acc <= sum - FRAME_DEN and step pulses high the following cycle (exactly one cycle).
REQ-021 At most one step per frame_tick per axis; dir equals sign of vel sampled at that frame_tick.
REQ-022 acc SHALL clear whenever vel is 0 or sign of vel changes.
REQ-023 frame_tick coincident with a velocity update SHALL use the pre-update vel.
REQ-024 game_active low: vel, acc, ramp counter forced to 0, steps held low, synchronous, next cycle; game_active rising resumes from zero state.

Reset
REQ-025 reset_n low SHALL asynchronously clear vel to 0, acc to 0, ramp counters to 0, step to 0, dir to 0.
REQ-026 Release SHALL be synchronised internally with a two-flop deassertion; first update no earlier than second cycle after release.
REQ-027 Reset mid-ramp or mid-frame SHALL discard all pending state; no step pulse emitted after reset.

Structure
REQ-028 Direction encodings (NONE/NEG/POS) and default parameter values SHALL live in shared package entity_pkg, reused by the edge-detect and sprite-position blocks.
REQ-029 One sub-module vector_axis (ramp, edge block, accumulator, step) SHALL be instantiated twice; top contains only reset sync and wiring.

Verification (MAX_SPEED=6, RAMP_DELAY=4, STEP_NUM=5, FRAME_DEN=60)
REQ-030 Hold input_hor=10 from reset, 30 cycles -> vel_hor 1,2..6 at 4-cycle spacing, then holds 6.
REQ-031 vel_hor=+6, input_hor=01 -> vel_hor 4, 2, 0, -1, -2 at 4-cycle spacing.
REQ-032 vel_hor=+3, 20 frame_ticks -> step_hor on ticks 4,8,12,16,20 (15/60), dir_hor=1, each one cycle wide.
REQ-033 vel_vert=+5, assert edge_bot -> vel_vert=0 next cycle, no further step_vert; input_vert=01 then ramps to -1.
REQ-034 reset_n pulse low mid-ramp with vel=-4 and acc=40 -> all outputs 0 immediately; no step after release until vel rebuilds.
REQ-035 game_active low while vel_hor=6, vel_vert=-3 -> both vel 0 next cycle; frame_ticks produce no steps.

Source files
------------

// File: rtl/entity_pkg.sv
// rtl/entity_pkg.sv - direction encodings, defaults and velocity helpers shared by entity blocks
package entity_pkg;

   typedef enum logic [1:0] {
      DIR_NONE = 2'b00,
      DIR_NEG  = 2'b01,
      DIR_POS  = 2'b10
   } dir_e;

   localparam int DEF_MAX_SPEED  = 6;
   localparam int DEF_RAMP_DELAY = 10_000_000;
   localparam int DEF_STEP_NUM   = 5;
   localparam int DEF_FRAME_DEN  = 60;

   // Both buttons pressed cancels out to no input.
   function automatic dir_e decode_dir(input logic [1:0] raw);
      case (raw)
         2'b01:   return DIR_NEG;
         2'b10:   return DIR_POS;
         default: return DIR_NONE;
      endcase
   endfunction

   function automatic int abs_int(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Pressing against the current motion brakes by two so reversals feel snappy.
   function automatic int ramp_velocity(input int v, input dir_e cmd, input int vmax);
      int n;
      case (cmd)
         DIR_POS: begin
            n = (v < 0) ? v + 2 : v + 1;
            if (n > vmax) n = vmax;
         end
         DIR_NEG: begin
            n = (v > 0) ? v - 2 : v - 1;
            if (n < -vmax) n = -vmax;
         end
         default: n = (v > 0) ? v - 1 : (v < 0) ? v + 1 : 0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/vector_axis.sv
// rtl/vector_axis.sv - one motion axis: velocity ramp, edge block, step accumulator
module vector_axis
   import entity_pkg::*;
#(
   parameter int MAX_SPEED  = DEF_MAX_SPEED,
   parameter int RAMP_DELAY = DEF_RAMP_DELAY,
   parameter int STEP_NUM   = DEF_STEP_NUM,
   parameter int FRAME_DEN  = DEF_FRAME_DEN,
   parameter int VEL_W      = 4,
   parameter int ACC_W      = 7
) (
   input  logic                    clock_100mhz,
   input  logic                    reset_n,
   input  logic                    game_active,
   input  logic                    frame_tick,
   input  logic [1:0]              dir_in,
   input  logic                    edge_neg,
   input  logic                    edge_pos,
   output logic signed [VEL_W-1:0] vel,
   output logic                    step,
   output logic                    dir
);

   localparam int RAMP_W = (RAMP_DELAY > 1) ? $clog2(RAMP_DELAY) : 1;
   localparam logic [RAMP_W-1:0] RAMP_LOAD = RAMP_W'(RAMP_DELAY - 1);

   logic [RAMP_W-1:0]       ramp_q, ramp_d;
   logic [ACC_W-1:0]        acc_q, acc_d;
   logic signed [VEL_W-1:0] vel_d;
   logic                    step_d, dir_d, blocked;
   dir_e                    cmd;
   int                      v_cur, v_tgt, sum;

   always_comb begin
      cmd     = decode_dir(dir_in);
      v_cur   = int'(vel);
      v_tgt   = ramp_velocity(v_cur, cmd, MAX_SPEED);
      blocked = ((v_cur > 0 || cmd == DIR_POS) && edge_pos) ||
                ((v_cur < 0 || cmd == DIR_NEG) && edge_neg);
      sum     = int'(acc_q) + abs_int(v_cur) * STEP_NUM;
      vel_d   = vel;
      ramp_d  = ramp_q;
      acc_d   = acc_q;
      step_d  = 1'b0;
      dir_d   = dir;
      if (!game_active) begin
         vel_d  = '0;
         ramp_d = '0;
         acc_d  = '0;
      end else begin
         if (blocked) begin
            vel_d  = '0;
            ramp_d = '0;
         end else if (ramp_q != '0) begin
            ramp_d = ramp_q - RAMP_W'(1);
         end else if (v_tgt != v_cur) begin
            vel_d  = VEL_W'(v_tgt);
            ramp_d = RAMP_LOAD;
         end
         // Stepping always uses the velocity held before this cycle's update.
         if (frame_tick && v_cur != 0) begin
            if (sum >= FRAME_DEN) begin
               acc_d  = ACC_W'(sum - FRAME_DEN);
               step_d = 1'b1;
               dir_d  = (v_cur > 0);
            end else begin
               acc_d  = ACC_W'(sum);
            end
         end
         if (vel_d == '0 || ((vel_d < 0) != (vel < 0)))
            acc_d = '0;
      end
   end

   always_ff @(posedge clock_100mhz or negedge reset_n) begin
      if (!reset_n) begin
         vel    <= '0;
         ramp_q <= '0;
         acc_q  <= '0;
         step   <= 1'b0;
         dir    <= 1'b0;
      end else begin
         vel    <= vel_d;
         ramp_q <= ramp_d;
         acc_q  <= acc_d;
         step   <= step_d;
         dir    <= dir_d;
      end
   end

endmodule

// File: rtl/entity_vector.sv
// rtl/entity_vector.sv - two-axis entity velocity and pixel-step generator
module entity_vector
   import entity_pkg::*;
#(
   parameter  int MAX_SPEED  = DEF_MAX_SPEED,
   parameter  int RAMP_DELAY = DEF_RAMP_DELAY,
   parameter  int STEP_NUM   = DEF_STEP_NUM,
   parameter  int FRAME_DEN  = DEF_FRAME_DEN,
   localparam int VEL_W      = $clog2(MAX_SPEED + 1) + 1,
   localparam int ACC_W      = $clog2(FRAME_DEN + MAX_SPEED * STEP_NUM)
) (
   input  logic                    clock_100mhz,
   input  logic                    reset_n,
   input  logic                    game_active,
   input  logic                    frame_tick,
   input  logic [1:0]              input_hor,
   input  logic [1:0]              input_vert,
   input  logic                    edge_left,
   input  logic                    edge_right,
   input  logic                    edge_top,
   input  logic                    edge_bot,
   output logic signed [VEL_W-1:0] vel_hor,
   output logic signed [VEL_W-1:0] vel_vert,
   output logic                    step_hor,
   output logic                    step_vert,
   output logic                    dir_hor,
   output logic                    dir_vert
);

   // Assert asynchronously, release two clocks later.
   logic [1:0] rst_sync;
   logic       axis_reset_n;

   always_ff @(posedge clock_100mhz or negedge reset_n) begin
      if (!reset_n) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end

   assign axis_reset_n = rst_sync[1];

   vector_axis #(
      .MAX_SPEED(MAX_SPEED), .RAMP_DELAY(RAMP_DELAY), .STEP_NUM(STEP_NUM),
      .FRAME_DEN(FRAME_DEN), .VEL_W(VEL_W), .ACC_W(ACC_W)
   ) u_hor (
      .clock_100mhz(clock_100mhz), .reset_n(axis_reset_n), .game_active(game_active),
      .frame_tick(frame_tick), .dir_in(input_hor), .edge_neg(edge_left), .edge_pos(edge_right),
      .vel(vel_hor), .step(step_hor), .dir(dir_hor)
   );

   vector_axis #(
      .MAX_SPEED(MAX_SPEED), .RAMP_DELAY(RAMP_DELAY), .STEP_NUM(STEP_NUM),
      .FRAME_DEN(FRAME_DEN), .VEL_W(VEL_W), .ACC_W(ACC_W)
   ) u_vert (
      .clock_100mhz(clock_100mhz), .reset_n(axis_reset_n), .game_active(game_active),
      .frame_tick(frame_tick), .dir_in(input_vert), .edge_neg(edge_top), .edge_pos(edge_bot),
      .vel(vel_vert), .step(step_vert), .dir(dir_vert)
   );

endmodule

// File: tb/tb_entity_vector.sv
// tb/tb_entity_vector.sv - self-checking bench for entity_vector
module tb_entity_vector;

   localparam int MAX_SPEED  = 6;
   localparam int RAMP_DELAY = 4;
   localparam int STEP_NUM   = 5;
   localparam int FRAME_DEN  = 60;
   localparam int VEL_W      = 4;

   logic clock_100mhz = 1'b0;
   logic reset_n, game_active, frame_tick;
   logic [1:0] input_hor, input_vert;
   logic edge_left, edge_right, edge_top, edge_bot;
   logic signed [VEL_W-1:0] vel_hor, vel_vert;
   logic step_hor, step_vert, dir_hor, dir_vert;

   always #5 clock_100mhz = ~clock_100mhz;

   entity_vector #(
      .MAX_SPEED(MAX_SPEED), .RAMP_DELAY(RAMP_DELAY), .STEP_NUM(STEP_NUM), .FRAME_DEN(FRAME_DEN)
   ) dut (
      .clock_100mhz(clock_100mhz), .reset_n(reset_n), .game_active(game_active),
      .frame_tick(frame_tick), .input_hor(input_hor), .input_vert(input_vert),
      .edge_left(edge_left), .edge_right(edge_right), .edge_top(edge_top), .edge_bot(edge_bot),
      .vel_hor(vel_hor), .vel_vert(vel_vert), .step_hor(step_hor), .step_vert(step_vert),
      .dir_hor(dir_hor), .dir_vert(dir_vert)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: motion rules in plain integer arithmetic, index 0 = hor, 1 = vert.
   int m_vel[2], m_cool[2], m_acc[2], m_step[2], m_dir[2];
   int m_rel = 0;

   task automatic model_reset();
      for (int a = 0; a < 2; a++) begin
         m_vel[a] = 0; m_cool[a] = 0; m_acc[a] = 0; m_step[a] = 0; m_dir[a] = 0;
      end
      m_rel = 0;
   endtask

   task automatic model_axis(input int a, input logic [1:0] raw, input logic e_neg, input logic e_pos);
      int old, want, sum;
      bit go_pos, go_neg;
      old = m_vel[a];
      m_step[a] = 0;
      if (!game_active) begin
         m_vel[a] = 0; m_cool[a] = 0; m_acc[a] = 0;
         return;
      end
      if (frame_tick && old != 0) begin
         sum = m_acc[a] + ((old < 0) ? -old : old) * STEP_NUM;
         if (sum >= FRAME_DEN) begin
            m_acc[a] = sum - FRAME_DEN; m_step[a] = 1; m_dir[a] = (old > 0) ? 1 : 0;
         end else m_acc[a] = sum;
      end
      go_pos = (raw == 2'b10);
      go_neg = (raw == 2'b01);
      if ((e_pos && (old > 0 || go_pos)) || (e_neg && (old < 0 || go_neg))) begin
         m_vel[a] = 0; m_cool[a] = 0;
      end else if (m_cool[a] > 0) begin
         m_cool[a] = m_cool[a] - 1;
      end else begin
         if (go_pos)      want = (old + ((old < 0) ? 2 : 1) > MAX_SPEED) ? MAX_SPEED : old + ((old < 0) ? 2 : 1);
         else if (go_neg) want = (old - ((old > 0) ? 2 : 1) < -MAX_SPEED) ? -MAX_SPEED : old - ((old > 0) ? 2 : 1);
         else             want = old - ((old > 0) ? 1 : (old < 0) ? -1 : 0);
         if (want != old) begin
            m_vel[a] = want; m_cool[a] = RAMP_DELAY - 1;
         end
      end
      if (m_vel[a] == 0 || (old != 0 && ((old < 0) != (m_vel[a] < 0)))) m_acc[a] = 0;
   endtask

   initial begin
      for (int a = 0; a < 2; a++) begin
         m_vel[a] = 0; m_cool[a] = 0; m_acc[a] = 0; m_step[a] = 0; m_dir[a] = 0;
      end
      forever begin
         @(negedge clock_100mhz);
         if (!reset_n) model_reset();
         chk("vel_hor", int'(vel_hor), m_vel[0]);
         chk("vel_vert", int'(vel_vert), m_vel[1]);
         chk("step_hor", int'(step_hor), m_step[0]);
         chk("step_vert", int'(step_vert), m_step[1]);
         if (m_step[0] != 0) chk("dir_hor", int'(dir_hor), m_dir[0]);
         if (m_step[1] != 0) chk("dir_vert", int'(dir_vert), m_dir[1]);
         if (reset_n) begin
            if (m_rel < 2) m_rel++;
            else begin
               model_axis(0, input_hor, edge_left, edge_right);
               model_axis(1, input_vert, edge_top, edge_bot);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clock_100mhz);
      #1;
   endtask

   function automatic int cur_vel(input int axis);
      return (axis == 0) ? int'(vel_hor) : int'(vel_vert);
   endfunction

   task automatic wait_vel(input string name, input int axis, input int val, input int budget);
      for (int i = 0; i < budget && cur_vel(axis) != val; i++) cyc(1);
      chk(name, cur_vel(axis), val);
   endtask

   int chg_val[$];
   int chg_t[$];

   task automatic track(input int axis, input int ncyc);
      int prev, cur;
      chg_val.delete();
      chg_t.delete();
      prev = cur_vel(axis);
      for (int i = 0; i < ncyc; i++) begin
         cyc(1);
         cur = cur_vel(axis);
         if (cur != prev) begin
            chg_val.push_back(cur); chg_t.push_back(i); prev = cur;
         end
      end
   endtask

   task automatic check_changes(input string name, input int exp[5], input int n);
      chk({name, " count"}, (chg_val.size() >= n) ? 1 : 0, 1);
      for (int i = 0; i < n; i++) begin
         chk({name, " value"}, (i < chg_val.size()) ? chg_val[i] : 99, exp[i]);
         if (i > 0) chk({name, " spacing"}, (i < chg_t.size()) ? chg_t[i] - chg_t[i-1] : 0, RAMP_DELAY);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_up[5], exp_rev[5];
      int steps, extra, at4, vel4, dir4;
      reset_n = 1'b1; game_active = 1'b1; frame_tick = 1'b0;
      input_hor = 2'b00; input_vert = 2'b00;
      edge_left = 1'b0; edge_right = 1'b0; edge_top = 1'b0; edge_bot = 1'b0;
      #1 reset_n = 1'b0;
      cyc(3);
      chk("reset vel_hor", int'(vel_hor), 0);
      chk("reset step_hor", int'(step_hor), 0);
      chk("reset dir_hor", int'(dir_hor), 0);

      // Ramp up from reset: 1..6 at four-cycle spacing, then hold at the clamp.
      input_hor = 2'b10;
      reset_n   = 1'b1;
      track(0, 32);
      exp_up = '{2, 3, 4, 5, 6};
      chk("ramp first value", (chg_val.size() > 0) ? chg_val[0] : 99, 1);
      if (chg_val.size() > 0) void'(chg_val.pop_front());
      if (chg_t.size() > 0) chk("ramp first spacing", (chg_t.size() > 1) ? chg_t[1] - chg_t[0] : 0, RAMP_DELAY);
      if (chg_t.size() > 0) void'(chg_t.pop_front());
      check_changes("ramp", exp_up, 5);
      chk("ramp hold at clamp", int'(vel_hor), 6);

      // At the clamp: 30/60 per tick, so steps follow every second tick.
      steps = 0; extra = 0;
      for (int k = 1; k <= 20; k++) begin
         frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
         chk("clamp step after tick", int'(step_hor), (k % 2 == 0) ? 1 : 0);
         if (step_hor) begin
            steps++;
            chk("clamp step dir", int'(dir_hor), 1);
         end
         cyc(1); if (step_hor) extra++;
         cyc(1); if (step_hor) extra++;
      end
      chk("clamp step count", steps, 10);
      chk("clamp step width", extra, 0);

      // Reversal braking: 6 -> 4, 2, 0, -1, -2.
      input_hor = 2'b01;
      track(0, 18);
      exp_rev = '{4, 2, 0, -1, -2};
      check_changes("reverse", exp_rev, 5);
      input_hor = 2'b00;
      wait_vel("decay to zero", 0, 0, 40);

      // vel=+3 window: 15/60 per tick, the fourth tick coincides with the 3->2 update.
      input_hor = 2'b10;
      wait_vel("reach +3", 0, 3, 40);
      input_hor = 2'b00; frame_tick = 1'b1;
      steps = 0; at4 = 0; vel4 = 0; dir4 = 0;
      for (int k = 1; k <= 4; k++) begin
         cyc(1);
         if (step_hor) steps++;
         if (k == 4) begin at4 = step_hor; vel4 = int'(vel_hor); dir4 = dir_hor; end
      end
      frame_tick = 1'b0;
      for (int k = 0; k < 3; k++) begin cyc(1); if (step_hor) steps++; end
      chk("window step on fourth tick", at4, 1);
      chk("window dir", dir4, 1);
      chk("window vel after update", vel4, 2);
      chk("window step count", steps, 1);
      wait_vel("window decay", 0, 0, 40);

      // Bottom edge stops downward motion at once; moving away is allowed.
      input_vert = 2'b10;
      wait_vel("vert reach +5", 1, 5, 40);
      edge_bot = 1'b1;
      cyc(1);
      chk("edge_bot stop", int'(vel_vert), 0);
      steps = 0;
      for (int k = 0; k < 4; k++) begin
         frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
         if (step_vert) steps++;
      end
      chk("edge_bot no steps", steps, 0);
      input_vert = 2'b01;
      for (int i = 0; i < 10 && vel_vert == 0; i++) cyc(1);
      chk("away from edge", int'(vel_vert), -1);
      edge_bot = 1'b0; input_vert = 2'b00;
      wait_vel("vert decay", 1, 0, 40);

      // Reset mid-ramp at vel=-4 with acc=40 pending.
      input_hor = 2'b01;
      wait_vel("reach -4", 0, -4, 40);
      input_hor = 2'b00; frame_tick = 1'b1;
      cyc(2);
      reset_n = 1'b0;
      #1;
      chk("async reset vel_hor", int'(vel_hor), 0);
      chk("async reset step_hor", int'(step_hor), 0);
      chk("async reset dir_hor", int'(dir_hor), 0);
      cyc(2);
      reset_n = 1'b1;
      steps = 0;
      for (int k = 0; k < 10; k++) begin cyc(1); if (step_hor) steps++; end
      frame_tick = 1'b0;
      chk("no step after reset", steps, 0);
      chk("vel zero after reset", int'(vel_hor), 0);
      input_hor = 2'b10;
      wait_vel("rebuild after reset", 0, 1, 10);

      // game_active low freezes both axes to the zero state.
      wait_vel("hor reach 4", 0, 4, 40);
      input_vert = 2'b01;
      wait_vel("vert reach -3", 1, -3, 40);
      chk("hor at clamp", int'(vel_hor), 6);
      game_active = 1'b0;
      cyc(1);
      chk("inactive vel_hor", int'(vel_hor), 0);
      chk("inactive vel_vert", int'(vel_vert), 0);
      steps = 0;
      for (int k = 0; k < 5; k++) begin
         frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
         if (step_hor || step_vert) steps++;
      end
      chk("inactive no steps", steps, 0);
      game_active = 1'b1;
      wait_vel("resume from zero", 0, 1, 10);
      cyc(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
